aq_div_sched: RTL and testbench
===============================

AQ_DIV_SCHED -- requirements
Module: aq_div_sched

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (2..8).
REQ-002 Parameter: DIV_LAT, 8, register stages in the external divider from a DIV_DINA/DIV_DINB capture edge to the edge that first presents DIV_DOUT.
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 EN  input  1  scheduler enable.
REQ-006 REQ_VALID  input  NREQ  per-requester operation request.
REQ-007 REQ_READY  output  NREQ  per-requester grant; one-hot or zero.
REQ-008 REQ_DINA  input  25*NREQ  dividends, requester i at [25i+24:25i].
REQ-009 REQ_DINB  input  16*NREQ  divisors, requester i at [16i+15:16i].
REQ-010 DIV_DINA  output  25  dividend to the shared divider, registered.
REQ-011 DIV_DINB  output  16  divisor to the shared divider, registered.
REQ-012 DIV_DOUT  input  8  quotient from the shared divider.
REQ-013 RES_VALID  output  1  one-cycle result strobe.
REQ-014 RES_ID  output  clog2(NREQ)  requester index that owns the result.
REQ-015 RES_DATA  output  8  result quotient.
REQ-016 RES_DZ  output  1  result came from a divide by zero.
REQ-017 BUSY  output  1  one or more operations are in flight.
REQ-018 STATE  output  2  FSM state: 0 IDLE, 1 RUN, 2 DRAIN.

Function
REQ-019 A transfer occurs on the rising edge where REQ_VALID[i] and REQ_READY[i] are both high. A requester holds its VALID and operands stable until that edge.
REQ-020 REQ_READY is combinational from REQ_VALID, the round-robin pointer and STATE. It is all-zero unless STATE=RUN.
REQ-021 Round-robin arbitration: search starts at index last_grant+1 and wraps modulo NREQ. last_grant updates only on a transfer. Reset value is NREQ-1, so requester 0 has first priority.
REQ-022 One transfer per cycle at most. Back-to-back transfers in consecutive cycles are allowed, giving a sustained throughput of one operation per clock.
REQ-023 On a transfer edge, the granted operands load into DIV_DINA/DIV_DINB. A tag {valid, id, dz} enters the tag pipe, with dz = (divisor == 0).
REQ-024 The tag pipe is DIV_LAT+1 stages deep. A tag written at edge E reaches the output stage at edge E+DIV_LAT+1, the same edge on which DIV_DOUT is sampled.
REQ-025 Result registers load at that edge: RES_VALID=1, RES_ID=tag id, RES_DATA=DIV_DOUT, or 8'hFF when dz=1, and RES_DZ=tag dz.
REQ-026 End-to-end latency is DIV_LAT+1 cycles: with DIV_LAT=8, a transfer at edge E gives RES_VALID high in the cycle after edge E+9.
REQ-027 RES_VALID is a single-cycle strobe per operation. No backpressure exists on results. The order of results equals the order of transfers.
REQ-028 When there is no transfer, DIV_DINA/DIV_DINB hold their values and a tag with valid=0 enters the pipe.
REQ-029 In-flight counter range is 0..DIV_LAT+1. It increments on a transfer and decrements on a result. When both happen on the same edge, the count is unchanged. BUSY = (count != 0).
REQ-030 FSM IDLE -> RUN when EN=1.
REQ-031 FSM RUN -> DRAIN when EN=0 and count != 0, or when EN=0 and a transfer occurs on the same edge.
REQ-032 FSM RUN -> IDLE when EN=0, count=0 and no transfer.
REQ-033 FSM DRAIN -> IDLE when the count reaches 0.
REQ-034 FSM DRAIN -> RUN when EN=1. Results continue to be delivered in DRAIN.
REQ-035 The EN sampled at an edge takes effect for READY in the following cycle. A grant that is combinationally high in the cycle EN falls still completes.

Reset
REQ-036 When RST=1 at an edge, the following load: STATE=IDLE, last_grant=NREQ-1, all tag valid bits=0, count=0, RES_VALID=0, RES_ID=0, RES_DATA=0, RES_DZ=0, DIV_DINA=0, DIV_DINB=0. BUSY=0 and REQ_READY=0 follow.
REQ-037 Reset mid-operation discards every in-flight operation: no RES_VALID for it after reset. Operands still inside the divider are ignored.
REQ-038 RST has priority over every other event on the same edge.

Verification
Each scenario uses a DIV_LAT=8 stub divider that returns DINA[7:0]^DINB[7:0] after 8 register stages.
REQ-039 Single op: EN=1, req0 A=25'h0000AB, B=16'h000F. Required: transfer at edge E, then RES_VALID only in the cycle after E+9, RES_ID=0, RES_DATA=8'hA4, RES_DZ=0.
REQ-040 Contention: all 4 REQ_VALID held high for 8 cycles. Required: grants in order 0,1,2,3,0,1,2,3, one per cycle, results in the same order on 8 consecutive cycles, BUSY high throughout.
REQ-041 Divide by zero: req2 B=16'h0000, A=25'h123. Required: RES_DATA=8'hFF, RES_DZ=1, RES_ID=2.
REQ-042 Drain: 3 back-to-back transfers, then EN=0. Required: STATE=DRAIN, no READY, all 3 results delivered, then STATE=IDLE and BUSY=0 in the cycle after the last result.
REQ-043 Reset mid-flight: RST=1 for one cycle 4 cycles after 2 transfers. Required: no RES_VALID afterwards, count=0, req0 granted first when operation resumes.
REQ-044 Same-edge event: a transfer on the same edge as a result. Required: count unchanged and BUSY stays high.

Source files
------------

// File: rtl/aq_div_sched.sv
`default_nettype none
// ============================================================================
//  Module      : aq_div_sched
//  Description : Round-robin scheduler that shares one pipelined divider
//                among NREQ requesters. Each accepted operation carries a
//                {valid, id, dz} tag down a pipe matched to the divider
//                latency so that the quotient is returned to its owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module aq_div_sched #(
  parameter int NREQ    = 4,
  parameter int DIV_LAT = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [NREQ-1:0]           REQ_VALID,
  output logic [NREQ-1:0]           REQ_READY,
  input  logic [25*NREQ-1:0]        REQ_DINA,
  input  logic [16*NREQ-1:0]        REQ_DINB,
  output logic [24:0]               DIV_DINA,
  output logic [15:0]               DIV_DINB,
  input  logic [7:0]                DIV_DOUT,
  output logic                      RES_VALID,
  output logic [$clog2(NREQ)-1:0]   RES_ID,
  output logic [7:0]                RES_DATA,
  output logic                      RES_DZ,
  output logic                      BUSY,
  output logic [1:0]                STATE
);

  localparam int c_ID_W  = $clog2(NREQ);
  localparam int c_CNT_W = $clog2(DIV_LAT + 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_ID_W-1:0]    r_last;
  logic [c_CNT_W-1:0]   r_cnt;

  // Tag pipe: stage 0 is written on the transfer edge, stage DIV_LAT is the
  // output stage consumed together with DIV_DOUT one edge later.
  logic                 r_tag_v  [0:DIV_LAT];
  logic [c_ID_W-1:0]    r_tag_id [0:DIV_LAT];
  logic                 r_tag_dz [0:DIV_LAT];

  logic                 w_found;
  logic [NREQ-1:0]      w_pick;
  logic [c_ID_W-1:0]    w_gid;
  logic [24:0]          w_sel_a;
  logic [15:0]          w_sel_b;
  logic                 w_xfer;
  logic                 w_dz;
  logic                 w_res;

  // Round-robin search: first the indices above last_grant, then wrap to
  // the indices at or below it, so the search order starts at last_grant+1.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_gid   = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && REQ_VALID[i] && (i > int'(r_last))) begin
        w_found   = 1'b1;
        w_pick[i] = 1'b1;
        w_gid     = c_ID_W'(i);
        w_sel_a   = REQ_DINA[25*i +: 25];
        w_sel_b   = REQ_DINB[16*i +: 16];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && REQ_VALID[i] && (i <= int'(r_last))) begin
        w_found   = 1'b1;
        w_pick[i] = 1'b1;
        w_gid     = c_ID_W'(i);
        w_sel_a   = REQ_DINA[25*i +: 25];
        w_sel_b   = REQ_DINB[16*i +: 16];
      end
    end
  end

  // Grants are only offered in RUN; a grant always targets a valid requester,
  // so any offered grant is a transfer on the coming edge.
  always_comb begin
    REQ_READY = '0;
    if (r_state == ST_RUN) begin
      REQ_READY = w_pick;
    end
  end

  assign w_xfer = (r_state == ST_RUN) && w_found;
  assign w_dz   = (w_sel_b == 16'h0000);
  assign w_res  = r_tag_v[DIV_LAT];
  assign BUSY   = (r_cnt != '0);
  assign STATE  = r_state;

  // Round-robin pointer moves only when a transfer happens.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last <= c_ID_W'(NREQ - 1);
    end else if (w_xfer) begin
      r_last <= w_gid;
    end
  end

  // Operand registers feeding the divider; they hold between transfers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DIV_DINA <= '0;
      DIV_DINB <= '0;
    end else if (w_xfer) begin
      DIV_DINA <= w_sel_a;
      DIV_DINB <= w_sel_b;
    end
  end

  // Tag pipe shift; an empty slot is inserted on cycles without a transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k <= DIV_LAT; k++) begin
        r_tag_v[k]  <= 1'b0;
        r_tag_id[k] <= '0;
        r_tag_dz[k] <= 1'b0;
      end
    end else begin
      r_tag_v[0]  <= w_xfer;
      r_tag_id[0] <= w_xfer ? w_gid : '0;
      r_tag_dz[0] <= w_xfer && w_dz;
      for (int k = 1; k <= DIV_LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
        r_tag_dz[k] <= r_tag_dz[k-1];
      end
    end
  end

  // Result registers: pair the output-stage tag with the divider quotient;
  // a divide by zero reports all-ones instead of the divider output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RES_VALID <= 1'b0;
      RES_ID    <= '0;
      RES_DATA  <= '0;
      RES_DZ    <= 1'b0;
    end else begin
      RES_VALID <= w_res;
      if (w_res) begin
        RES_ID   <= r_tag_id[DIV_LAT];
        RES_DATA <= r_tag_dz[DIV_LAT] ? 8'hFF : DIV_DOUT;
        RES_DZ   <= r_tag_dz[DIV_LAT];
      end
    end
  end

  // In-flight counter: a transfer and a result on the same edge cancel.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else begin
      case ({w_xfer, w_res})
        2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Scheduler state: RUN offers grants, DRAIN only returns results.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (EN) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!EN) begin
            if ((r_cnt != '0) || w_xfer) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (EN) begin
            r_state <= ST_RUN;
          end else if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aq_div_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aq_div_sched
//  Description : Directed self-checking bench for aq_div_sched with an
//                8-stage XOR stub standing in for the shared divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aq_div_sched;

  localparam int c_NREQ = 4;
  localparam int c_LAT  = 8;

  logic           CLK;
  logic           RST;
  logic           EN;
  logic [3:0]     REQ_VALID;
  logic [3:0]     REQ_READY;
  logic [99:0]    REQ_DINA;
  logic [63:0]    REQ_DINB;
  logic [24:0]    DIV_DINA;
  logic [15:0]    DIV_DINB;
  logic [7:0]     DIV_DOUT;
  logic           RES_VALID;
  logic [1:0]     RES_ID;
  logic [7:0]     RES_DATA;
  logic           RES_DZ;
  logic           BUSY;
  logic [1:0]     STATE;

  int n_checks = 0;
  int n_fail   = 0;

  aq_div_sched #(.NREQ(c_NREQ), .DIV_LAT(c_LAT)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_DINA  (REQ_DINA),
    .REQ_DINB  (REQ_DINB),
    .DIV_DINA  (DIV_DINA),
    .DIV_DINB  (DIV_DINB),
    .DIV_DOUT  (DIV_DOUT),
    .RES_VALID (RES_VALID),
    .RES_ID    (RES_ID),
    .RES_DATA  (RES_DATA),
    .RES_DZ    (RES_DZ),
    .BUSY      (BUSY),
    .STATE     (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stub divider: DINA[7:0]^DINB[7:0] through 8 register stages.
  logic [7:0] r_stub [0:7];
  initial for (int k = 0; k < 8; k++) r_stub[k] = 8'h00;
  always @(posedge CLK) begin
    r_stub[0] <= DIV_DINA[7:0] ^ DIV_DINB[7:0];
    for (int k = 1; k < 8; k++) r_stub[k] <= r_stub[k-1];
  end
  assign DIV_DOUT = r_stub[7];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b0; REQ_VALID = 4'b0000;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic start_run();
    EN = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b1; REQ_VALID = 4'hF;
    REQ_DINA = '1; REQ_DINB = '1;
    tick(); tick();
    #1;
    n_checks++; if (STATE !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", STATE); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    n_checks++; if (REQ_READY !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", REQ_READY); end
    n_checks++; if ({RES_VALID, RES_ID, RES_DATA, RES_DZ} !== 12'h000) begin n_fail++; $display("FAIL reset_res: got v=%b id=%0d d=%h dz=%b expected all zero", RES_VALID, RES_ID, RES_DATA, RES_DZ); end
    n_checks++; if ({DIV_DINA, DIV_DINB} !== 41'h0) begin n_fail++; $display("FAIL reset_div: got a=%h b=%h expected 0", DIV_DINA, DIV_DINB); end
    RST = 1'b0; REQ_VALID = 4'b0000;
  endtask

  task automatic test_single();
    do_reset();
    start_run();
    n_checks++; if (STATE !== 2'd1) begin n_fail++; $display("FAIL single_run_state: got %0d expected 1", STATE); end
    REQ_DINA = '0; REQ_DINB = '0;
    REQ_DINA[24:0] = 25'h0000AB;
    REQ_DINB[15:0] = 16'h000F;
    for (int t = 0; t < 12; t++) begin
      REQ_VALID = (t == 0) ? 4'b0001 : 4'b0000;
      #1;
      if (t == 0) begin
        n_checks++; if (REQ_READY !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b expected 0001", REQ_READY); end
      end
      tick();
      if (t == 0) begin
        n_checks++; if (DIV_DINA !== 25'h0000AB || DIV_DINB !== 16'h000F) begin n_fail++; $display("FAIL single_div_in: got a=%h b=%h expected 0000ab 000f", DIV_DINA, DIV_DINB); end
      end
      n_checks++; if (RES_VALID !== (t == 9)) begin n_fail++; $display("FAIL single_res_valid t=%0d: got %b expected %b", t, RES_VALID, (t == 9)); end
      n_checks++; if (BUSY !== (t < 9)) begin n_fail++; $display("FAIL single_busy t=%0d: got %b expected %b", t, BUSY, (t < 9)); end
      if (t == 9) begin
        n_checks++; if (RES_ID !== 2'd0 || RES_DATA !== 8'hA4 || RES_DZ !== 1'b0) begin n_fail++; $display("FAIL single_res: got id=%0d d=%h dz=%b expected 0 a4 0", RES_ID, RES_DATA, RES_DZ); end
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_id;
    logic [7:0] exp_d;
    do_reset();
    start_run();
    for (int i = 0; i < 4; i++) begin
      REQ_DINA[25*i +: 25] = 25'(8'h10 + i);
      REQ_DINB[16*i +: 16] = 16'(1 << i);
    end
    for (int t = 0; t < 20; t++) begin
      REQ_VALID = (t < 8) ? 4'hF : 4'h0;
      #1;
      if (t < 8) begin
        n_checks++; if (REQ_READY !== 4'(1 << (t % 4))) begin n_fail++; $display("FAIL cont_grant t=%0d: got %b expected %b", t, REQ_READY, 4'(1 << (t % 4))); end
      end
      tick();
      n_checks++; if (RES_VALID !== (t >= 9 && t <= 16)) begin n_fail++; $display("FAIL cont_res_valid t=%0d: got %b expected %b", t, RES_VALID, (t >= 9 && t <= 16)); end
      n_checks++; if (BUSY !== (t < 16)) begin n_fail++; $display("FAIL cont_busy t=%0d: got %b expected %b", t, BUSY, (t < 16)); end
      if (t >= 9 && t <= 16) begin
        exp_id = 2'((t - 9) % 4);
        exp_d  = (8'h10 + 8'(exp_id)) ^ 8'(1 << exp_id);
        n_checks++; if (RES_ID !== exp_id || RES_DATA !== exp_d || RES_DZ !== 1'b0) begin n_fail++; $display("FAIL cont_res t=%0d: got id=%0d d=%h dz=%b expected %0d %h 0", t, RES_ID, RES_DATA, RES_DZ, exp_id, exp_d); end
      end
    end
  endtask

  task automatic test_div_zero();
    do_reset();
    start_run();
    REQ_DINA = '0; REQ_DINB = '1;
    REQ_DINA[50 +: 25] = 25'h123;
    REQ_DINB[32 +: 16] = 16'h0000;
    for (int t = 0; t < 11; t++) begin
      REQ_VALID = (t == 0) ? 4'b0100 : 4'b0000;
      #1;
      if (t == 0) begin
        n_checks++; if (REQ_READY !== 4'b0100) begin n_fail++; $display("FAIL dz_ready: got %b expected 0100", REQ_READY); end
      end
      tick();
      n_checks++; if (RES_VALID !== (t == 9)) begin n_fail++; $display("FAIL dz_res_valid t=%0d: got %b expected %b", t, RES_VALID, (t == 9)); end
      if (t == 9) begin
        n_checks++; if (RES_ID !== 2'd2 || RES_DATA !== 8'hFF || RES_DZ !== 1'b1) begin n_fail++; $display("FAIL dz_res: got id=%0d d=%h dz=%b expected 2 ff 1", RES_ID, RES_DATA, RES_DZ); end
      end
    end
  endtask

  task automatic test_drain();
    logic [1:0] exp_state;
    do_reset();
    start_run();
    REQ_DINA = '0; REQ_DINB = '1;
    for (int t = 0; t < 16; t++) begin
      EN        = (t < 2) ? 1'b1 : 1'b0;
      REQ_VALID = (t < 3) ? 4'b0111 : 4'b0001;
      #1;
      n_checks++; if (REQ_READY !== ((t < 3) ? 4'(1 << t) : 4'b0000)) begin n_fail++; $display("FAIL drain_ready t=%0d: got %b expected %b", t, REQ_READY, ((t < 3) ? 4'(1 << t) : 4'b0000)); end
      tick();
      exp_state = (t <= 1) ? 2'd1 : ((t <= 11) ? 2'd2 : 2'd0);
      n_checks++; if (STATE !== exp_state) begin n_fail++; $display("FAIL drain_state t=%0d: got %0d expected %0d", t, STATE, exp_state); end
      n_checks++; if (RES_VALID !== (t >= 9 && t <= 11)) begin n_fail++; $display("FAIL drain_res_valid t=%0d: got %b expected %b", t, RES_VALID, (t >= 9 && t <= 11)); end
      n_checks++; if (BUSY !== (t < 11)) begin n_fail++; $display("FAIL drain_busy t=%0d: got %b expected %b", t, BUSY, (t < 11)); end
      if (t >= 9 && t <= 11) begin
        n_checks++; if (RES_ID !== 2'(t - 9)) begin n_fail++; $display("FAIL drain_res_id t=%0d: got %0d expected %0d", t, RES_ID, t - 9); end
      end
    end
    REQ_VALID = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_run();
    REQ_DINA = '0; REQ_DINB = '1;
    for (int t = 0; t < 5; t++) begin
      REQ_VALID = (t < 2) ? 4'b0110 : 4'b0000;
      tick();
    end
    n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", BUSY); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_checks++; if (STATE !== 2'd0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL rmid_after_rst: got state=%0d busy=%b expected 0 0", STATE, BUSY); end
    for (int t = 6; t < 15; t++) begin
      tick();
      n_checks++; if (RES_VALID !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet t=%0d: got v=%b busy=%b expected 0 0", t, RES_VALID, BUSY); end
    end
    REQ_VALID = 4'hF;
    #1;
    n_checks++; if (REQ_READY !== 4'b0001) begin n_fail++; $display("FAIL rmid_first_grant: got %b expected 0001", REQ_READY); end
    tick();
    REQ_VALID = 4'h0;
    n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL rmid_resume_busy: got %b expected 1", BUSY); end
    do_reset();
  endtask

  task automatic test_same_edge();
    do_reset();
    start_run();
    REQ_DINA = '0; REQ_DINB = '1;
    for (int t = 0; t < 20; t++) begin
      REQ_VALID = (t == 0 || t == 9) ? 4'b1000 : 4'b0000;
      #1;
      if (t == 0 || t == 9) begin
        n_checks++; if (REQ_READY !== 4'b1000) begin n_fail++; $display("FAIL same_ready t=%0d: got %b expected 1000", t, REQ_READY); end
      end
      tick();
      n_checks++; if (RES_VALID !== (t == 9 || t == 18)) begin n_fail++; $display("FAIL same_res_valid t=%0d: got %b expected %b", t, RES_VALID, (t == 9 || t == 18)); end
      n_checks++; if (BUSY !== (t < 18)) begin n_fail++; $display("FAIL same_busy t=%0d: got %b expected %b", t, BUSY, (t < 18)); end
    end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; REQ_VALID = 4'b0000;
    REQ_DINA = '0; REQ_DINB = '0;
    test_reset();
    test_single();
    test_contention();
    test_div_zero();
    test_drain();
    test_reset_mid();
    test_same_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
